// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the three handshakes of the memory-access stage.
//   ALU side      : in_valid/in_ready plus the instruction operands.
//   Data port     : mem_req/mem_gnt request channel, mem_rvalid/mem_rdata response.
//   Writeback side: wb_valid/wb_ready plus the result fields and misalign flag.
// Modport slave is the stage's view; modport master is the surrounding
// pipeline/memory view.
interface mem_stage_if #(
    parameter int BUS_DATA_WIDTH = 64
);
    // ALU-side handshake and operands
    logic                          in_valid;
    logic                          in_ready;
    logic [BUS_DATA_WIDTH-1:0]     alu_result;
    logic [BUS_DATA_WIDTH-1:0]     store_data;
    logic                          is_load;
    logic                          is_store;
    logic [2:0]                    mem_size;
    logic [4:0]                    rd;

    // Single-outstanding data port
    logic                          mem_req;
    logic [BUS_DATA_WIDTH-1:0]     mem_addr;
    logic                          mem_we;
    logic [BUS_DATA_WIDTH-1:0]     mem_wdata;
    logic [BUS_DATA_WIDTH/8-1:0]   mem_wstrb;
    logic                          mem_gnt;
    logic                          mem_rvalid;
    logic [BUS_DATA_WIDTH-1:0]     mem_rdata;

    // Writeback-side handshake and result
    logic                          wb_valid;
    logic                          wb_ready;
    logic [BUS_DATA_WIDTH-1:0]     wb_data;
    logic [4:0]                    wb_rd;
    logic                          wb_we;
    logic                          misalign;

    modport slave (
        input  in_valid, alu_result, store_data, is_load, is_store, mem_size, rd,
        output in_ready,
        output mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output wb_valid, wb_data, wb_rd, wb_we, misalign,
        input  wb_ready
    );

    modport master (
        output in_valid, alu_result, store_data, is_load, is_store, mem_size, rd,
        input  in_ready,
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  wb_valid, wb_data, wb_rd, wb_we, misalign,
        output wb_ready
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between ALU and writeback.
// Non-memory results pass straight to writeback; loads and stores go out over
// a single-outstanding request/response data port. Load data is aligned and
// sign/zero-extended; every instruction yields exactly one registered
// writeback result.
// Ports:
//   clk     - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - mem_stage_if.slave (ALU input, data port, writeback output)
module mem_stage #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    mem_stage_if.slave  bus
);
    localparam int DW = BUS_DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_WAIT = 2'b10;
    localparam logic [1:0] S_OUT  = 2'b11;

    // Byte-enable pattern for an access of 2**sz bytes at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            2'b11:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // An access is misaligned when the byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] sz);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            2'b10:   r = |off[1:0];
            2'b11:   r = |off;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Extend the low bytes of already-shifted load data according to funct3.
    function automatic logic [DW-1:0] load_extend(input logic [DW-1:0] sh, input logic [2:0] f3);
        logic [DW-1:0] r;
        case (f3)
            3'b000:  r = {{56{sh[7]}},  sh[7:0]};
            3'b001:  r = {{48{sh[15]}}, sh[15:0]};
            3'b010:  r = {{32{sh[31]}}, sh[31:0]};
            3'b100:  r = {56'd0, sh[7:0]};
            3'b101:  r = {48'd0, sh[15:0]};
            3'b110:  r = {32'd0, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [2:0]    offset_q, offset_d;
    logic [2:0]    size_q, size_d;
    logic          mem_req_q, mem_req_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]    mem_wstrb_q, mem_wstrb_d;
    logic          wb_valid_q, wb_valid_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_we_q, wb_we_d;
    logic          misalign_q, misalign_d;

    logic          in_ready_s;
    logic          accept_s;
    logic          is_mem_s;
    logic          misalign_s;

    // Input is taken in IDLE, or in OUT when writeback drains the current result this cycle.
    always_comb begin
        in_ready_s = (state_q == S_IDLE) | ((state_q == S_OUT) & bus.wb_ready);
        accept_s   = bus.in_valid & in_ready_s;
        // Load and store both set is an illegal encoding, handled as a pass-through.
        is_mem_s   = bus.is_load ^ bus.is_store;
        misalign_s = is_misaligned(bus.alu_result[2:0], bus.mem_size[1:0]);
    end

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        size_d      = size_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        misalign_d  = misalign_q;

        if (accept_s) begin
            // A new instruction replaces whatever was just handed to writeback.
            wb_rd_d  = bus.rd;
            offset_d = bus.alu_result[2:0];
            size_d   = bus.mem_size;
            if (!is_mem_s) begin
                state_d    = S_OUT;
                wb_valid_d = 1'b1;
                wb_data_d  = bus.alu_result;
                wb_we_d    = (bus.rd != 5'd0);
                misalign_d = 1'b0;
            end else if (misalign_s) begin
                state_d    = S_OUT;
                wb_valid_d = 1'b1;
                wb_data_d  = {DW{1'b0}};
                wb_we_d    = 1'b0;
                misalign_d = 1'b1;
            end else begin
                state_d    = S_REQ;
                wb_valid_d = 1'b0;
                wb_we_d    = 1'b0;
                misalign_d = 1'b0;
                mem_req_d  = 1'b1;
                mem_addr_d = {bus.alu_result[DW-1:3], 3'b000};
                mem_we_d   = bus.is_store;
                if (bus.is_store) begin
                    mem_wdata_d = bus.store_data << {bus.alu_result[2:0], 3'b000};
                    mem_wstrb_d = size_mask(bus.mem_size[1:0]) << bus.alu_result[2:0];
                end else begin
                    mem_wdata_d = {DW{1'b0}};
                    mem_wstrb_d = 8'h00;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_d = 1'b0;
                        if (mem_we_q) begin
                            state_d    = S_OUT;
                            wb_valid_d = 1'b1;
                            wb_data_d  = {DW{1'b0}};
                            wb_we_d    = 1'b0;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        mem_req_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        state_d    = S_OUT;
                        wb_valid_d = 1'b1;
                        wb_data_d  = load_extend(bus.mem_rdata >> {offset_q, 3'b000}, size_q);
                        wb_we_d    = (wb_rd_q != 5'd0);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_OUT: begin
                    if (bus.wb_ready) begin
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b0;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            offset_q    <= 3'd0;
            size_q      <= 3'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= {DW{1'b0}};
            mem_we_q    <= 1'b0;
            mem_wdata_q <= {DW{1'b0}};
            mem_wstrb_q <= 8'h00;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= {DW{1'b0}};
            wb_rd_q     <= 5'd0;
            wb_we_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_we     = wb_we_q;
    assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected writeback results
// and expected data-port requests are queued when an input is accepted and
// compared when the stage produces them; directed tests add cycle-exact checks.
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_stage_if bus ();
    mem_stage dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
    } exp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    exp_t        expq[$];
    req_t        reqq[$];
    logic [63:0] rdq[$];
    int          total = 0;
    int          bad   = 0;
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    logic [63:0] mem_word  = 64'd0;
    exp_t        mon_e;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one instruction at writeback.
    function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] word, input logic [4:0] r);
        exp_t        e;
        logic [63:0] sh;
        int          nb;
        int          off;
        nb     = 1 << f3[1:0];
        off    = int'(a[2:0]);
        e.rd   = r;
        e.we   = 1'b0;
        e.mis  = 1'b0;
        e.data = 64'd0;
        if (ld == st) begin
            e.data = a;
            e.we   = (r != 5'd0);
        end else if ((off % nb) != 0) begin
            e.mis = 1'b1;
        end else if (st) begin
            e.data = 64'd0;
        end else begin
            sh = word >> (8 * off);
            case (f3)
                3'd0:    e.data = 64'($signed(sh[7:0]));
                3'd1:    e.data = 64'($signed(sh[15:0]));
                3'd2:    e.data = 64'($signed(sh[31:0]));
                3'd4:    e.data = 64'(sh[7:0]);
                3'd5:    e.data = 64'(sh[15:0]);
                3'd6:    e.data = 64'(sh[31:0]);
                default: e.data = sh;
            endcase
            e.we = (r != 5'd0);
        end
        return e;
    endfunction

    function automatic req_t req_model(input logic st, input logic [2:0] f3,
                                       input logic [63:0] a, input logic [63:0] sd);
        req_t q;
        int   nb;
        int   off;
        int   m;
        nb      = 1 << f3[1:0];
        off     = int'(a[2:0]);
        m       = ((1 << nb) - 1) << off;
        q.addr  = {a[63:3], 3'b000};
        q.we    = st;
        q.wdata = sd << (8 * off);
        q.wstrb = m[7:0];
        return q;
    endfunction

    // Writeback monitor and scoreboard feeder, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.wb_valid && bus.wb_ready) begin
                if (expq.size() == 0) begin
                    check_val("wb_unexpected", bus.wb_valid, 1'b0);
                end else begin
                    mon_e = expq.pop_front();
                    if (!mon_e.mis) check_val("wb_data", bus.wb_data, mon_e.data);
                    check_val("wb_rd", bus.wb_rd, mon_e.rd);
                    check_val("wb_we", bus.wb_we, mon_e.we);
                    check_val("misalign", bus.misalign, mon_e.mis);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                mon_e = model(bus.is_load, bus.is_store, bus.mem_size, bus.alu_result, mem_word, bus.rd);
                expq.push_back(mon_e);
                if ((bus.is_load != bus.is_store) && !mon_e.mis) begin
                    reqq.push_back(req_model(bus.is_store, bus.mem_size, bus.alu_result, bus.store_data));
                    if (bus.is_load) rdq.push_back(mem_word);
                end
            end
        end
    end

    // Data-port responder: grant after gnt_delay request cycles, data rv_delay cycles after the grant.
    initial begin
        int   cnt;
        int   rcnt;
        logic rpend;
        req_t q;
        cnt = 0; rcnt = 0; rpend = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'd0;
        forever begin
            @(posedge clk); #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (rpend) begin
                if (rcnt >= rv_delay) begin
                    bus.mem_rvalid = 1'b1;
                    if (rdq.size() != 0) bus.mem_rdata = rdq.pop_front();
                    else bus.mem_rdata = 64'd0;
                    rpend = 1'b0;
                end else begin
                    rcnt++;
                end
            end
            if (bus.mem_req) begin
                if (cnt >= gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    cnt = 0;
                    if (reqq.size() == 0) begin
                        check_val("req_unexpected", bus.mem_req, 1'b0);
                    end else begin
                        q = reqq.pop_front();
                        check_val("req_addr", bus.mem_addr, q.addr);
                        check_val("req_we", bus.mem_we, q.we);
                        if (q.we) begin
                            check_val("req_wdata", bus.mem_wdata, q.wdata);
                            check_val("req_wstrb", bus.mem_wstrb, q.wstrb);
                        end
                    end
                    if (!bus.mem_we) begin
                        rpend = 1'b1;
                        rcnt  = 0;
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one instruction and hold it until accepted; returns one cycle after acceptance.
    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] sd, input logic [4:0] r, input bit rand_wb);
        bus.is_load    = ld;
        bus.is_store   = st;
        bus.mem_size   = f3;
        bus.alu_result = a;
        bus.store_data = sd;
        bus.rd         = r;
        bus.in_valid   = 1'b1;
        #1;
        for (int i = 0; i < 200 && !bus.in_ready; i++) begin
            tick();
            if (rand_wb) bus.wb_ready = 1'($urandom_range(0, 1));
            #1;
        end
        check_val("accept_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] ra;
        int          kind;
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_result = 64'd0; bus.store_data = 64'd0;
        bus.is_load = 1'b0; bus.is_store = 1'b0; bus.mem_size = 3'd0; bus.rd = 5'd0;
        bus.wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", bus.in_ready, 1'b1);
        check_val("rst_mem_req", bus.mem_req, 1'b0);
        check_val("rst_mem_addr", bus.mem_addr, 64'd0);
        check_val("rst_wb_valid", bus.wb_valid, 1'b0);
        check_val("rst_wb_data", bus.wb_data, 64'd0);
        check_val("rst_mem_wstrb", bus.mem_wstrb, 8'h00);
        reset_n = 1'b1;
        tick();

        // Pass-through, back to back, rd=5 then rd=0.
        drive_op(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b0);
        check_val("pt_valid", bus.wb_valid, 1'b1);
        check_val("pt_data", bus.wb_data, 64'h1234);
        check_val("pt_we", bus.wb_we, 1'b1);
        check_val("pt_no_req", bus.mem_req, 1'b0);
        drive_op(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd0, 1'b0);
        check_val("pt0_valid", bus.wb_valid, 1'b1);
        check_val("pt0_we", bus.wb_we, 1'b0);
        check_val("pt0_no_req", bus.mem_req, 1'b0);
        tick();
        check_val("pt_idle", bus.wb_valid, 1'b0);

        // lb / lbu at 0x1003, minimum latency.
        for (int k = 0; k < 2; k++) begin
            mem_word = 64'h00000000_80FF0000;
            drive_op(1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 64'h1003, 64'd0, 5'd3, 1'b0);
            check_val("lb_req", bus.mem_req, 1'b1);
            check_val("lb_addr", bus.mem_addr, 64'h1000);
            check_val("lb_wb_n1", bus.wb_valid, 1'b0);
            tick();
            check_val("lb_wait_noreq", bus.mem_req, 1'b0);
            check_val("lb_wb_n2", bus.wb_valid, 1'b0);
            tick();
            check_val("lb_wb_n3", bus.wb_valid, 1'b1);
            check_val("lb_data", bus.wb_data, (k == 0) ? 64'hFFFFFFFFFFFFFF80 : 64'h80);
            tick();
        end

        // sh at 0x2006 with grant delayed three cycles.
        gnt_delay = 3;
        drive_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd9, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_val("sh_req", bus.mem_req, 1'b1);
            check_val("sh_addr", bus.mem_addr, 64'h2000);
            check_val("sh_wstrb", bus.mem_wstrb, 8'hC0);
            check_val("sh_wdata", bus.mem_wdata, 64'hABCD000000000000);
            check_val("sh_we", bus.mem_we, 1'b1);
            check_val("sh_wb_early", bus.wb_valid, 1'b0);
            tick();
        end
        check_val("sh_wb_valid", bus.wb_valid, 1'b1);
        check_val("sh_wb_we", bus.wb_we, 1'b0);
        check_val("sh_req_done", bus.mem_req, 1'b0);
        gnt_delay = 0;
        tick();

        // Misaligned lw at 0x3002.
        drive_op(1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 5'd4, 1'b0);
        check_val("mis_valid", bus.wb_valid, 1'b1);
        check_val("mis_flag", bus.misalign, 1'b1);
        check_val("mis_we", bus.wb_we, 1'b0);
        check_val("mis_no_req", bus.mem_req, 1'b0);
        tick();
        check_val("mis_no_req2", bus.mem_req, 1'b0);

        // Backpressure: four stalled cycles, then same-cycle accept on release.
        bus.wb_ready = 1'b0;
        drive_op(1'b0, 1'b0, 3'd0, 64'h55, 64'd0, 5'd7, 1'b0);
        bus.alu_result = 64'h66; bus.rd = 5'd8; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("bp_in_ready", bus.in_ready, 1'b0);
            check_val("bp_valid", bus.wb_valid, 1'b1);
            check_val("bp_data", bus.wb_data, 64'h55);
            check_val("bp_rd", bus.wb_rd, 5'd7);
            check_val("bp_we", bus.wb_we, 1'b1);
            @(posedge clk);
        end
        #1;
        bus.wb_ready = 1'b1;
        #1;
        check_val("bp_release_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check_val("bp_next_valid", bus.wb_valid, 1'b1);
        check_val("bp_next_data", bus.wb_data, 64'h66);
        tick();
        check_val("bp_idle", bus.wb_valid, 1'b0);

        // Reset pulsed while waiting for load data; the late response is ignored.
        rv_delay = 4;
        mem_word = 64'h1122334455667788;
        drive_op(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd10, 1'b0);
        tick();
        check_val("rw_wait_noreq", bus.mem_req, 1'b0);
        reset_n = 1'b0;
        #1;
        check_val("rw_in_ready", bus.in_ready, 1'b1);
        check_val("rw_mem_addr", bus.mem_addr, 64'd0);
        check_val("rw_mem_we", bus.mem_we, 1'b0);
        check_val("rw_wb_valid", bus.wb_valid, 1'b0);
        check_val("rw_wb_rd", bus.wb_rd, 5'd0);
        check_val("rw_wb_we", bus.wb_we, 1'b0);
        check_val("rw_misalign", bus.misalign, 1'b0);
        tick();
        reset_n = 1'b1;
        expq.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("rw_no_wb", bus.wb_valid, 1'b0);
        end
        rdq.delete();
        reqq.delete();
        rv_delay = 0;

        // Random mix with random port latencies and writeback stalls.
        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 3);
            ra   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ra[2:0] = 3'd0;
            gnt_delay = $urandom_range(0, 3);
            rv_delay  = $urandom_range(0, 3);
            mem_word  = {$urandom, $urandom};
            case (kind)
                0: drive_op(1'b0, 1'b0, 3'($urandom_range(0, 7)), ra, 64'd0, 5'($urandom_range(0, 31)), 1'b1);
                1: drive_op(1'b1, 1'b0, 3'($urandom_range(0, 6)), ra, 64'd0, 5'($urandom_range(0, 31)), 1'b1);
                2: drive_op(1'b0, 1'b1, 3'($urandom_range(0, 3)), ra, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'b1);
                default: drive_op(1'b1, 1'b1, 3'($urandom_range(0, 7)), ra, 64'd0, 5'($urandom_range(0, 31)), 1'b1);
            endcase
        end
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 500 && expq.size() != 0; i++) tick();
        check_val("drain_wb", expq.size(), 0);
        check_val("drain_req", reqq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the ALU and writeback. It accepts one ALU result per handshake and passes non-memory results straight through. For loads and stores it drives a single-outstanding request/response data port, aligns and extends load data, and presents one registered result per instruction to writeback.

## Interface
- BUS_DATA_WIDTH, 64, data/address width; only 64 is supported.
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept an input this cycle.
- alu_result  in  64  ALU output: effective address for load/store, result otherwise.
- store_data  in  64  rs2 value for stores.
- is_load / is_store  in  1 each  op class; both low means a non-memory op; both high is illegal.
- mem_size  in  3  funct3 encoding. Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Stores: 000–011.
- rd  in  5  destination register.
- mem_req  out  1  data-port request.
- mem_addr  out  64  {alu_result[63:3],3'b000}.
- mem_we  out  1  request is a store.
- mem_wdata  out  64  store data shifted to byte lane.
- mem_wstrb  out  8  byte enables.
- mem_gnt  in  1  port accepted the request this cycle.
- mem_rvalid  in  1  load data valid; arrives at or after the cycle after mem_gnt.
- mem_rdata  in  64  aligned 64-bit word.
- wb_valid  out  1  result for writeback.
- wb_ready  in  1  writeback accepts.
- wb_data  out  64  result.
- wb_rd  out  5  destination register.
- wb_we  out  1  register write enable.
- misalign  out  1  qualified by wb_valid; the access was misaligned.

## Operation
- States: IDLE, REQ, WAIT, OUT.
- IDLE, input handshake (in_valid & in_ready):
  - non-memory op → OUT with wb_data=alu_result, wb_we=(rd!=0).
  - misaligned access (offset = alu_result[2:0] not a multiple of the access size) → OUT with misalign=1, wb_we=0; no request is issued.
  - otherwise latch the operands → REQ.
- REQ:
  - mem_req=1; address, data and strobe held stable until mem_gnt.
  - On mem_gnt, a store → OUT with wb_we=0, wb_data=0.
  - On mem_gnt, a load → WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: shifted = mem_rdata >> (8·offset); extend per mem_size (signed types sign-extend from bit 7/15/31, unsigned types zero-extend); wb_data = extended value, wb_we=(rd!=0) → OUT.
- OUT:
  - wb_valid=1; wb_* held stable until wb_ready.
  - On wb_ready → IDLE.
- Stores: wstrb = size mask (0x01, 0x03, 0x0F, 0xFF) << offset; wdata = store_data << (8·offset).
- in_ready = (state==IDLE) | (state==OUT & wb_ready & next input is a non-memory op is NOT assumed). in_ready is therefore high in IDLE, and also in OUT when wb_ready=1; an input accepted in OUT is processed exactly as from IDLE in the same cycle.
- is_load & is_store together: treated as a non-memory op, result passed through.

## Timing
- Reset values: state IDLE, in_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, wb_valid=0, wb_data=0, wb_rd=0, wb_we=0, misalign=0.
- Non-memory op: accepted at cycle N, wb_valid at N+1. Back-to-back throughput is 1 per cycle while wb_ready=1.
- Store: accepted at N, mem_req at N+1. With gnt at cycle G, wb_valid at G+1.
- Load: rvalid at cycle R gives wb_valid at R+1. Minimum latency is 3 cycles (gnt at N+1, rvalid at N+2).
- mem_gnt and mem_rvalid are ignored outside REQ and WAIT respectively.
- wb_ready low in OUT: the stage stalls and in_ready=0.
- Reset mid-operation: immediate return to reset values; an in-flight response after reset is ignored.

## Test plan
- Pass-through with wb_ready=1: add result 0x1234, rd=5, then rd=0 → wb_data 0x1234 with wb_we=1 at N+1; next cycle wb_we=0; no mem_req.
- lb at address 0x1003 with mem_rdata=0x00000000_80FF0000, gnt at N+1, rvalid at N+2 → wb_data 0xFFFFFFFFFFFFFF80 at N+3. The same with lbu → 0x80.
- sh at address 0x2006, store_data 0xABCD, gnt delayed 3 cycles → mem_addr 0x2000, wstrb 0xC0, wdata 0xABCD<<48, all stable until gnt; wb_valid with wb_we=0.
- Misaligned lw at address 0x3002 → no mem_req; wb_valid at N+1 with misalign=1, wb_we=0.
- Backpressure: wb_ready held low 4 cycles during OUT → in_ready=0 and wb_* stable throughout; on release, the next op is accepted in the same cycle.
- reset_n pulsed low during WAIT → outputs return to reset values immediately; a later rvalid produces no wb_valid.
